// File: rtl/ws2812_pkg.sv
// Shared constants and state encoding for the WS2812 serializer.
// Default timings assume a 48 MHz clock.
package ws2812_pkg;

  localparam int unsigned PIXEL_BITS         = 24;
  localparam int unsigned DEF_BIT_CYCLES     = 60;
  localparam int unsigned DEF_T0H_CYCLES     = 19;
  localparam int unsigned DEF_T1H_CYCLES     = 38;
  localparam int unsigned DEF_LATCH_CYCLES   = 14400;
  localparam int unsigned DEF_LOAD_DELAY     = 2;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    SHIFT,
    LATCH
  } state_e;

endpackage

// File: rtl/ws2812_tx_if.sv
// Sequencer/RAM side of the WS2812 serializer plus its line outputs.
interface ws2812_tx_if import ws2812_pkg::*; ();

  logic                  active;
  logic [PIXEL_BITS-1:0] pixel;
  logic                  next;
  logic                  dout;
  logic                  busy;

  modport master (output active, output pixel, input next, input dout, input busy);
  modport slave  (input active, input pixel, output next, output dout, output busy);

endinterface

// File: rtl/ws2812_tx.sv
// WS2812 one-wire serializer: captures 24-bit pixels, shifts them out MSB
// first with NRZ pulse timing and holds the line low for the latch period.
module ws2812_tx import ws2812_pkg::*; #(
  parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int unsigned T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int unsigned T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int unsigned LOAD_DELAY   = DEF_LOAD_DELAY
) (
  input logic        clk,
  input logic        reset,
  ws2812_tx_if.slave tx
);

  localparam int unsigned CW = $clog2(BIT_CYCLES);
  localparam int unsigned WW = $clog2(LOAD_DELAY + 1);
  localparam int unsigned BW = $clog2(PIXEL_BITS);
  localparam int unsigned LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H_LAST  = CW'(T0H_CYCLES - 1);
  localparam logic [CW-1:0] T1H_LAST  = CW'(T1H_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(LOAD_DELAY);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PIXEL_BITS - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(LATCH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [PIXEL_BITS-1:0] shreg_q, shreg_d;
  logic                  dout_q, dout_d;
  logic                  load;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx.active) begin
          state_d = PREFETCH;
          wait_d  = WW'(1);
        end
      end
      PREFETCH: begin
        if (!tx.active) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          load = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cyc_q == CYC_LAST) begin
          if (bit_q != BIT_LAST) begin
            shreg_d = {shreg_q[PIXEL_BITS-2:0], 1'b0};
            bit_d   = bit_q + 1'b1;
            cyc_d   = '0;
            dout_d  = 1'b1;
          end else if (tx.active) begin
            load = 1'b1;
          end else begin
            state_d = LATCH;
            lat_d   = '0;
            cyc_d   = '0;
            bit_d   = '0;
            dout_d  = 1'b0;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
          // dout_d describes the cycle where cyc becomes cyc_q+1, hence *_LAST
          dout_d = dout_q && (cyc_q < (shreg_q[PIXEL_BITS-1] ? T1H_LAST : T0H_LAST));
        end
      end
      LATCH: begin
        if (lat_q == LAT_LAST) begin
          state_d = IDLE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = SHIFT;
      shreg_d = tx.pixel;
      bit_d   = '0;
      cyc_d   = '0;
      wait_d  = '0;
      dout_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
      shreg_q <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      lat_q   <= lat_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
    end
  end

  assign tx.next = load && !reset;
  assign tx.dout = dout_q;
  assign tx.busy = (state_q != IDLE);

endmodule
